// File: rtl/field_pkg.sv
// field_pkg: shared types and saturating helpers for the vector-field updater.
//   COMP_W       width of one component (xn, yn, mag)
//   FIELD_DATAW  RAM word width, three components packed {xn, yn, mag}
//   field_mode_t operation applied to every cell during a sweep
//   field_state_t sweep controller state, also exported for observation
//   field_cell_t packed RAM word view
//   sat_s / sat_u / abs_s  clamp and magnitude helpers sized from COMP_W
package field_pkg;

    localparam int COMP_W      = 32;
    localparam int FIELD_DATAW = 3 * COMP_W;

    typedef enum logic [1:0] {
        FIELD_CLEAR = 2'd0,
        FIELD_DECAY = 2'd1,
        FIELD_ADD   = 2'd2,
        FIELD_RSVD  = 2'd3
    } field_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } field_state_t;

    typedef struct packed {
        logic signed [COMP_W-1:0] xn;
        logic signed [COMP_W-1:0] yn;
        logic        [COMP_W-1:0] mag;
    } field_cell_t;

    // Clamp a (COMP_W+1)-bit signed sum into COMP_W bits. Overflow shows up
    // as the two top bits disagreeing; the top bit then gives the direction.
    function automatic logic signed [COMP_W-1:0] sat_s(input logic signed [COMP_W:0] v);
        logic signed [COMP_W-1:0] r;
        if (v[COMP_W] != v[COMP_W-1]) begin
            r = v[COMP_W] ? {1'b1, {(COMP_W-1){1'b0}}} : {1'b0, {(COMP_W-1){1'b1}}};
        end else begin
            r = v[COMP_W-1:0];
        end
        return r;
    endfunction

    // Clamp a (COMP_W+1)-bit unsigned sum to all-ones.
    function automatic logic [COMP_W-1:0] sat_u(input logic [COMP_W:0] v);
        logic [COMP_W-1:0] r;
        r = v[COMP_W] ? {COMP_W{1'b1}} : v[COMP_W-1:0];
        return r;
    endfunction

    // Magnitude returned unsigned, so the most negative value maps exactly
    // onto 2^(COMP_W-1).
    function automatic logic [COMP_W-1:0] abs_s(input logic signed [COMP_W-1:0] v);
        logic [COMP_W-1:0] r;
        r = v[COMP_W-1] ? (~v + {{(COMP_W-1){1'b0}}, 1'b1}) : v;
        return r;
    endfunction

endpackage

// File: rtl/field_cell_alu.sv
// field_cell_alu: purely combinational per-cell operation.
//   mode      operation select (CLEAR / DECAY / ADD / RSVD)
//   force_x   signed x increment used by ADD
//   force_y   signed y increment used by ADD
//   cell_in   current cell word
//   cell_out  updated cell word (RSVD passes the cell through unchanged)
module field_cell_alu
    import field_pkg::*;
#(
    parameter int DECAY_SHIFT = 4
) (
    input  field_mode_t              mode,
    input  logic signed [COMP_W-1:0] force_x,
    input  logic signed [COMP_W-1:0] force_y,
    input  field_cell_t              cell_in,
    output field_cell_t              cell_out
);

    logic        [COMP_W:0]   sum_x;
    logic        [COMP_W:0]   sum_y;
    logic signed [COMP_W-1:0] add_x;
    logic signed [COMP_W-1:0] add_y;
    logic        [COMP_W:0]   mag_sum;

    always_comb begin
        // Sign-extend one bit so the raw sum cannot wrap before clamping.
        sum_x   = {cell_in.xn[COMP_W-1], cell_in.xn} + {force_x[COMP_W-1], force_x};
        sum_y   = {cell_in.yn[COMP_W-1], cell_in.yn} + {force_y[COMP_W-1], force_y};
        add_x   = sat_s(sum_x);
        add_y   = sat_s(sum_y);
        mag_sum = {1'b0, abs_s(add_x)} + {1'b0, abs_s(add_y)};

        cell_out = cell_in;
        case (mode)
            FIELD_CLEAR: cell_out = '0;
            FIELD_DECAY: begin
                cell_out.xn  = cell_in.xn - (cell_in.xn >>> DECAY_SHIFT);
                cell_out.yn  = cell_in.yn - (cell_in.yn >>> DECAY_SHIFT);
                cell_out.mag = cell_in.mag - (cell_in.mag >> DECAY_SHIFT);
            end
            FIELD_ADD: begin
                cell_out.xn  = add_x;
                cell_out.yn  = add_y;
                cell_out.mag = sat_u(mag_sum);
            end
            default: cell_out = cell_in;
        endcase
    end

endmodule

// File: rtl/field_updater.sv
// field_updater: sweeps every cell of the field RAM in raster order and
// rewrites it through field_cell_alu, one cell per clock.
//   clk, reset        clock; asynchronous active-low reset
//   start             begin a sweep (only looked at in IDLE)
//   mode              operation, latched with force_x/force_y at start
//   busy              high from the first read cycle to the last write cycle
//   done              single-cycle pulse after the sweep
//   field_addr_read   RAM read address (data returns one cycle later)
//   field_data_out    RAM read data
//   field_addr_write  RAM write address
//   field_data_in     RAM write data
//   field_we          RAM write enable
//   state_dbg         current controller state
// Handshake: start is a level sampled on a clock edge while IDLE; the
// sequencer then waits for the done pulse. There is no back-pressure, the
// RAM accepts a read and a write every cycle.
// Pipeline: S0 drives the read address, S1 holds that address while the RAM
// returns its data and the ALU result is registered into the write port
// registers, which form S2. Each write lands two cycles after its read.
module field_updater
    import field_pkg::*;
#(
    parameter int FIELD_WIDTH  = 8,
    parameter int FIELD_HEIGHT = 6,
    parameter int DECAY_SHIFT  = 4,
    localparam int FIELD_SIZE  = FIELD_WIDTH * FIELD_HEIGHT,
    localparam int FIELD_ADDRW = $clog2(FIELD_SIZE)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [1:0]             mode,
    input  logic [COMP_W-1:0]      force_x,
    input  logic [COMP_W-1:0]      force_y,
    output logic                   busy,
    output logic                   done,
    output logic [FIELD_ADDRW-1:0] field_addr_read,
    input  logic [FIELD_DATAW-1:0] field_data_out,
    output logic [FIELD_ADDRW-1:0] field_addr_write,
    output logic [FIELD_DATAW-1:0] field_data_in,
    output logic                   field_we,
    output field_state_t           state_dbg
);

    localparam logic [FIELD_ADDRW-1:0] LAST_ADDR = FIELD_ADDRW'(FIELD_SIZE - 1);
    localparam logic [FIELD_ADDRW-1:0] ADDR_ONE  = FIELD_ADDRW'(1);

    field_state_t             state_q,      state_d;
    field_mode_t              mode_q,       mode_d;
    logic [COMP_W-1:0]        force_x_q,    force_x_d;
    logic [COMP_W-1:0]        force_y_q,    force_y_d;
    logic                     rd_valid_q,   rd_valid_d;
    logic [FIELD_ADDRW-1:0]   addr_read_q,  addr_read_d;
    logic                     s1_valid_q,   s1_valid_d;
    logic [FIELD_ADDRW-1:0]   s1_addr_q,    s1_addr_d;
    logic                     we_q,         we_d;
    logic [FIELD_ADDRW-1:0]   addr_write_q, addr_write_d;
    logic [FIELD_DATAW-1:0]   data_in_q,    data_in_d;
    logic                     busy_q,       busy_d;
    logic                     done_q,       done_d;

    field_cell_t alu_out;

    field_cell_alu #(
        .DECAY_SHIFT (DECAY_SHIFT)
    ) u_alu (
        .mode     (mode_q),
        .force_x  (force_x_q),
        .force_y  (force_y_q),
        .cell_in  (field_cell_t'(field_data_out)),
        .cell_out (alu_out)
    );

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        force_x_d   = force_x_q;
        force_y_d   = force_y_q;
        rd_valid_d  = 1'b0;
        addr_read_d = addr_read_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        // The S1/S2 stages advance unconditionally; only the valid bits
        // decide whether a write actually happens.
        s1_valid_d   = rd_valid_q;
        s1_addr_d    = addr_read_q;
        we_d         = s1_valid_q;
        addr_write_d = s1_valid_q ? s1_addr_q : addr_write_q;
        data_in_d    = s1_valid_q ? FIELD_DATAW'(alu_out) : data_in_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (field_mode_t'(mode) == FIELD_RSVD) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d     = ST_RUN;
                        mode_d      = field_mode_t'(mode);
                        force_x_d   = force_x;
                        force_y_d   = force_y;
                        addr_read_d = '0;
                        rd_valid_d  = 1'b1;
                        busy_d      = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (addr_read_q == LAST_ADDR) begin
                    state_d = ST_DRAIN;
                end else begin
                    addr_read_d = addr_read_q + ADDR_ONE;
                    rd_valid_d  = 1'b1;
                end
            end
            ST_DRAIN: begin
                // Once S1 is empty the final write is already in the output
                // registers this cycle, so done can follow right after it.
                if (!s1_valid_q) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            mode_q       <= FIELD_CLEAR;
            force_x_q    <= '0;
            force_y_q    <= '0;
            rd_valid_q   <= 1'b0;
            addr_read_q  <= '0;
            s1_valid_q   <= 1'b0;
            s1_addr_q    <= '0;
            we_q         <= 1'b0;
            addr_write_q <= '0;
            data_in_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            force_x_q    <= force_x_d;
            force_y_q    <= force_y_d;
            rd_valid_q   <= rd_valid_d;
            addr_read_q  <= addr_read_d;
            s1_valid_q   <= s1_valid_d;
            s1_addr_q    <= s1_addr_d;
            we_q         <= we_d;
            addr_write_q <= addr_write_d;
            data_in_q    <= data_in_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign field_addr_read  = addr_read_q;
    assign field_addr_write = addr_write_q;
    assign field_data_in    = data_in_q;
    assign field_we         = we_q;
    assign state_dbg        = state_q;

endmodule
